// File: rtl/ahb_slave_if.sv
`timescale 1ns/1ps
// AHB-Lite slave front end of the AHB-to-APB bridge.
// Accepts address phases, decodes one of three APB regions and registers
// address/control/write data for the APB controller. The master is held with
// hready_out low until apb_done; out-of-range accesses get a two-cycle ERROR.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new address phase, OKAY response
// BUSY  | transfer handed to APB side, master stalled until apb_done
// ERR1  | first ERROR cycle, hready_out low
// ERR2  | second ERROR cycle, hready_out high, any new address phase dropped
module ahb_slave_if #(
  parameter logic [31:0] BASE0 = 32'h8000_0000,
  parameter logic [31:0] BASE1 = 32'h8400_0000,
  parameter logic [31:0] BASE2 = 32'h8800_0000,
  parameter logic [31:0] RSIZE = 32'h0400_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        apb_done,
  input  logic [31:0] prdata,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hr_data,
  output logic        valid,
  output logic [31:0] haddr_1,
  output logic [31:0] hwdata_1,
  output logic        hwrite_reg,
  output logic [2:0]  temp_selx
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic        hready_out_q, hready_out_d;
  logic [1:0]  hresp_q, hresp_d;
  logic        valid_q, valid_d;
  logic [31:0] haddr_1_q, haddr_1_d;
  logic [31:0] hwdata_1_q, hwdata_1_d;
  logic        hwrite_reg_q, hwrite_reg_d;
  logic [2:0]  temp_selx_q, temp_selx_d;
  logic [31:0] hr_data_q, hr_data_d;

  logic [2:0]  sel_dec;
  logic        in_range;
  logic        accept;

  // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  logic        unused_htrans0;
  assign unused_htrans0 = htrans[0];

  // Combinational region decode of the current address phase.
  always_comb begin
    sel_dec = 3'b000;
    if ((haddr >= BASE0) && (haddr < BASE0 + RSIZE)) sel_dec = 3'b001;
    else if ((haddr >= BASE1) && (haddr < BASE1 + RSIZE)) sel_dec = 3'b010;
    else if ((haddr >= BASE2) && (haddr < BASE2 + RSIZE)) sel_dec = 3'b100;
  end

  assign in_range = |sel_dec;
  assign accept   = hready_in & hready_out_q & htrans[1];

  // State and registered outputs; reset overrides any in-flight event.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_q      <= S_IDLE;
      hready_out_q <= 1'b1;
      hresp_q      <= RESP_OKAY;
      valid_q      <= 1'b0;
      haddr_1_q    <= '0;
      hwdata_1_q   <= '0;
      hwrite_reg_q <= 1'b0;
      temp_selx_q  <= '0;
      hr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      hready_out_q <= hready_out_d;
      hresp_q      <= hresp_d;
      valid_q      <= valid_d;
      haddr_1_q    <= haddr_1_d;
      hwdata_1_q   <= hwdata_1_d;
      hwrite_reg_q <= hwrite_reg_d;
      temp_selx_q  <= temp_selx_d;
      hr_data_q    <= hr_data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    hready_out_d = hready_out_q;
    hresp_d      = hresp_q;
    valid_d      = 1'b0;
    haddr_1_d    = haddr_1_q;
    hwdata_1_d   = hwdata_1_q;
    hwrite_reg_d = hwrite_reg_q;
    temp_selx_d  = temp_selx_q;
    hr_data_d    = hr_data_q;

    unique case (state_q)
      S_IDLE: begin
        hready_out_d = 1'b1;
        hresp_d      = RESP_OKAY;
        if (accept && in_range) begin
          state_d      = S_BUSY;
          hready_out_d = 1'b0;
          valid_d      = 1'b1;
          haddr_1_d    = haddr;
          hwrite_reg_d = hwrite;
          temp_selx_d  = sel_dec;
        end else if (accept) begin
          state_d      = S_ERR1;
          hready_out_d = 1'b0;
          hresp_d      = RESP_ERROR;
        end
      end
      S_BUSY: begin
        // valid_q doubles as the first-BUSY-cycle (data phase) marker.
        if (valid_q && hwrite_reg_q) hwdata_1_d = hwdata;
        if (apb_done) begin
          state_d      = S_IDLE;
          hready_out_d = 1'b1;
          temp_selx_d  = 3'b000;
          if (!hwrite_reg_q) hr_data_d = prdata;
        end
      end
      S_ERR1: begin
        state_d      = S_ERR2;
        hready_out_d = 1'b1;
        hresp_d      = RESP_ERROR;
      end
      S_ERR2: begin
        state_d      = S_IDLE;
        hready_out_d = 1'b1;
        hresp_d      = RESP_OKAY;
      end
      default: begin
        state_d      = S_IDLE;
        hready_out_d = 1'b1;
        hresp_d      = RESP_OKAY;
      end
    endcase
  end

  assign hready_out = hready_out_q;
  assign hresp      = hresp_q;
  assign hr_data    = hr_data_q;
  assign valid      = valid_q;
  assign haddr_1    = haddr_1_q;
  assign hwdata_1   = hwdata_1_q;
  assign hwrite_reg = hwrite_reg_q;
  assign temp_selx  = temp_selx_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
`timescale 1ns/1ps
// Bench for ahb_slave_if: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ahb_slave_if;

  localparam logic [31:0] BASE0 = 32'h8000_0000;
  localparam logic [31:0] RSIZE = 32'h0400_0000;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        apb_done;
  logic [31:0] prdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hr_data;
  logic        valid;
  logic [31:0] haddr_1;
  logic [31:0] hwdata_1;
  logic        hwrite_reg;
  logic [2:0]  temp_selx;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  ahb_slave_if dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .apb_done(apb_done),
    .prdata(prdata), .hready_out(hready_out), .hresp(hresp), .hr_data(hr_data),
    .valid(valid), .haddr_1(haddr_1), .hwdata_1(hwdata_1),
    .hwrite_reg(hwrite_reg), .temp_selx(temp_selx)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a transfer is either in flight (with its age
  // in cycles), an error response with cycles remaining, or nothing.
  bit          m_rdy, m_valid, m_wr;
  logic [1:0]  m_resp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_sel;
  bit          xfer_on;
  int          xfer_age;
  int          err_left;
  int unsigned rgn;

  always @(posedge hclk) begin
    if (hresetn) begin
      m_rdy = 1; m_resp = 0; m_valid = 0; m_wr = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_sel = 0;
      xfer_on = 0; xfer_age = 0; err_left = 0;
    end else begin
      m_valid = 0;
      if (xfer_on) begin
        if (xfer_age == 0 && m_wr) m_wdata = hwdata;
        xfer_age++;
        if (apb_done) begin
          xfer_on = 0;
          m_rdy = 1;
          m_sel = 0;
          if (!m_wr) m_rdata = prdata;
        end
      end else if (err_left != 0) begin
        err_left--;
        m_rdy = 1;
        m_resp = (err_left != 0) ? 2'b01 : 2'b00;
      end else if (hready_in && (htrans == 2'd2 || htrans == 2'd3)) begin
        rgn = (haddr >= BASE0) ? (haddr - BASE0) / RSIZE : 99;
        if (rgn < 3) begin
          xfer_on = 1; xfer_age = 0;
          m_valid = 1; m_rdy = 0;
          m_addr = haddr; m_wr = hwrite;
          m_sel = 3'(1 << rgn);
        end else begin
          err_left = 2;
          m_rdy = 0;
          m_resp = 2'b01;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge hclk) begin
    if (chk_en) begin
      cmp("hready_out", 32'(hready_out), 32'(m_rdy));
      cmp("hresp", 32'(hresp), 32'(m_resp));
      cmp("valid", 32'(valid), 32'(m_valid));
      cmp("haddr_1", haddr_1, m_addr);
      cmp("hwdata_1", hwdata_1, m_wdata);
      cmp("hwrite_reg", 32'(hwrite_reg), 32'(m_wr));
      cmp("temp_selx", 32'(temp_selx), 32'(m_sel));
      cmp("hr_data", hr_data, m_rdata);
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h83FF_FFFF;
      3: return 32'h8400_0000;
      4: return 32'h8BFF_FFFF;
      5: return 32'h8C00_0000;
      6: return $urandom;
      default: return 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
    endcase
  endfunction

  initial begin
    hresetn = 1; hwrite = 0; hready_in = 1; htrans = 0; haddr = 0;
    hwdata = 0; apb_done = 0; prdata = 0;
    repeat (2) @(negedge hclk);
    chk_en = 1;
    cmp("rst_hready", 32'(hready_out), 32'd1);
    cmp("rst_hresp", 32'(hresp), 32'd0);
    cmp("rst_valid", 32'(valid), 32'd0);
    cmp("rst_selx", 32'(temp_selx), 32'd0);
    cmp("rst_hrdata", hr_data, 32'd0);
    hresetn = 0;

    // Write to region 0
    htrans = 2; hwrite = 1; haddr = 32'h8000_0001;
    @(negedge hclk);
    htrans = 0; haddr = 0; hwdata = 32'h8202_0613;
    cmp("wr_valid", 32'(valid), 32'd1);
    cmp("wr_hready", 32'(hready_out), 32'd0);
    cmp("wr_addr", haddr_1, 32'h8000_0001);
    cmp("wr_selx", 32'(temp_selx), 32'b001);
    @(negedge hclk);
    hwdata = 32'h1111_2222;
    cmp("wr_valid_once", 32'(valid), 32'd0);
    cmp("wr_data", hwdata_1, 32'h8202_0613);
    @(negedge hclk);
    cmp("wr_hold", 32'(hready_out), 32'd0);
    apb_done = 1;
    @(negedge hclk);
    apb_done = 0;
    cmp("wr_ready_back", 32'(hready_out), 32'd1);
    cmp("wr_data_kept", hwdata_1, 32'h8202_0613);

    // Read from region 1
    htrans = 2; hwrite = 0; haddr = 32'h8400_0003;
    @(negedge hclk);
    htrans = 0;
    cmp("rd_selx", 32'(temp_selx), 32'b010);
    cmp("rd_hresp", 32'(hresp), 32'd0);
    prdata = 32'hDEAD_BEEF; apb_done = 1;
    @(negedge hclk);
    apb_done = 0; prdata = 0;
    cmp("rd_data", hr_data, 32'hDEAD_BEEF);
    cmp("rd_ready", 32'(hready_out), 32'd1);

    // Out-of-range access
    htrans = 2; haddr = 32'h9000_0000;
    @(negedge hclk);
    htrans = 0;
    cmp("err1_hready", 32'(hready_out), 32'd0);
    cmp("err1_hresp", 32'(hresp), 32'd1);
    cmp("err1_valid", 32'(valid), 32'd0);
    @(negedge hclk);
    cmp("err2_hready", 32'(hready_out), 32'd1);
    cmp("err2_hresp", 32'(hresp), 32'd1);
    @(negedge hclk);
    cmp("err_done_hresp", 32'(hresp), 32'd0);

    // IDLE htrans and region boundaries
    htrans = 0; haddr = 32'h8000_0000;
    @(negedge hclk);
    cmp("idle_valid", 32'(valid), 32'd0);
    htrans = 3; haddr = 32'h8BFF_FFFF;
    @(negedge hclk);
    htrans = 0;
    cmp("bnd_selx", 32'(temp_selx), 32'b100);
    apb_done = 1;
    @(negedge hclk);
    apb_done = 0;
    htrans = 2; haddr = 32'h8C00_0000;
    @(negedge hclk);
    htrans = 0;
    cmp("bnd_err", 32'(hresp), 32'd1);
    repeat (2) @(negedge hclk);

    // Reset during BUSY with a simultaneous apb_done
    htrans = 2; hwrite = 0; haddr = 32'h8800_0010;
    @(negedge hclk);
    htrans = 0;
    cmp("rb_busy", 32'(hready_out), 32'd0);
    hresetn = 1; apb_done = 1; prdata = 32'hCAFE_F00D;
    @(negedge hclk);
    hresetn = 0; apb_done = 0;
    cmp("rb_hrdata", hr_data, 32'd0);
    cmp("rb_hready", 32'(hready_out), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (hready_out) begin
        htrans = 2'($urandom_range(0, 3));
        hwrite = 1'($urandom_range(0, 1));
        haddr  = pick_addr();
      end
      hready_in = ($urandom_range(0, 7) != 0);
      hwdata    = $urandom;
      prdata    = $urandom;
      apb_done  = ($urandom_range(0, 3) == 0);
      hresetn   = ($urandom_range(0, 199) == 0);
      @(negedge hclk);
    end
    hresetn = 0; htrans = 0; apb_done = 0;
    @(negedge hclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
